// File: rtl/pong_game.sv
// Pong game logic and 3/3/2 pixel colouring, fed by the VGA sync generator's hc/vc/vidon.
// Define PONG_ATTRACT_EN for attract mode: the left paddle tracks the ball and up/dn are ignored.
module pong_game #(
  parameter logic [9:0] HBP          = 10'd144,
  parameter logic [9:0] VBP          = 10'd31,
  parameter logic [9:0] HACT         = 10'd640,
  parameter logic [9:0] VACT         = 10'd480,
  parameter logic [9:0] PAD_W        = 10'd8,
  parameter logic [9:0] PAD_H        = 10'd64,
  parameter logic [9:0] LX           = 10'd16,
  parameter logic [9:0] BALL         = 10'd8,
  parameter logic [9:0] BALL_STEP    = 10'd2,
  parameter logic [9:0] PAD_STEP     = 10'd4,
  parameter logic [9:0] AI_STEP      = 10'd2,
  parameter logic [9:0] SERVE_FRAMES = 10'd60,
  parameter logic [3:0] WIN_SCORE    = 4'd9
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       vidon,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic       up,
  input  logic       dn,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue,
  output logic [3:0] score_l,
  output logic [3:0] score_r
);

  localparam logic [9:0] RX     = HACT - LX - PAD_W;
  localparam logic [9:0] PY_MAX = VACT - PAD_H;
  localparam logic [9:0] BX_MAX = HACT - BALL;
  localparam logic [9:0] BY_MAX = VACT - BALL;
  localparam logic [9:0] PY_C   = PY_MAX >> 1;
  localparam logic [9:0] BX_C   = BX_MAX >> 1;
  localparam logic [9:0] BY_C   = BY_MAX >> 1;
  localparam logic [9:0] NET_R  = HACT >> 1;
  localparam logic [9:0] NET_L  = NET_R - 10'd1;

  typedef enum logic [1:0] {SERVE, PLAY, OVER} state_t;

  state_t     state;
  logic [9:0] cnt;
  logic [9:0] py_l, py_r, bx, by;
  logic       dx, dy;
  logic [9:0] py_l_nx, py_r_nx, bx_nx, by_nx;
  logic       dx_nx, dy_nx, miss_l, miss_r;
  logic       ovl_l, ovl_r, tick;
  logic [9:0] x, y;
  logic       in_ball, in_lpad, in_rpad, in_net;

  // Move a paddle one step toward the ball centre, holding inside a small dead band.
  function automatic logic [9:0] track_step(input logic [9:0] py, input logic [9:0] ball_y);
    logic [9:0] bc, pc;
    bc = ball_y + (BALL >> 1);
    pc = py + (PAD_H >> 1);
    if (bc > pc + AI_STEP)
      track_step = (py + AI_STEP > PY_MAX) ? PY_MAX : py + AI_STEP;
    else if (pc > bc + AI_STEP)
      track_step = (py < AI_STEP) ? 10'd0 : py - AI_STEP;
    else
      track_step = py;
  endfunction

  assign tick  = (hc == 10'd0) && (vc == VBP + VACT);
  assign ovl_l = (by + BALL > py_l) && (by < py_l + PAD_H);
  assign ovl_r = (by + BALL > py_r) && (by < py_r + PAD_H);

  assign py_r_nx = track_step(py_r, by);

`ifdef PONG_ATTRACT_EN
  logic unused_buttons;
  assign unused_buttons = up ^ dn;
  assign py_l_nx = track_step(py_l, by);
`else
  always_comb begin
    py_l_nx = py_l;
    if (up && !dn)
      py_l_nx = (py_l < PAD_STEP) ? 10'd0 : py_l - PAD_STEP;
    else if (dn && !up)
      py_l_nx = (py_l + PAD_STEP > PY_MAX) ? PY_MAX : py_l + PAD_STEP;
  end
`endif

  // Vertical ball motion with wall reflection; compares are ordered so nothing wraps.
  always_comb begin
    by_nx = by;
    dy_nx = dy;
    if (!dy) begin
      if (by < BALL_STEP) begin
        by_nx = 10'd0;
        dy_nx = 1'b1;
      end else begin
        by_nx = by - BALL_STEP;
      end
    end else begin
      if (by + BALL_STEP > BY_MAX) begin
        by_nx = BY_MAX;
        dy_nx = 1'b0;
      end else begin
        by_nx = by + BALL_STEP;
      end
    end
  end

  // Horizontal motion: a paddle return wins over a miss when both would apply.
  always_comb begin
    bx_nx  = bx;
    dx_nx  = dx;
    miss_l = 1'b0;
    miss_r = 1'b0;
    if (!dx) begin
      if ((bx < LX + PAD_W + BALL_STEP) && ovl_l) begin
        bx_nx = LX + PAD_W;
        dx_nx = 1'b1;
      end else if (bx < BALL_STEP) begin
        miss_l = 1'b1;
      end else begin
        bx_nx = bx - BALL_STEP;
      end
    end else begin
      if ((bx + BALL + BALL_STEP > RX) && ovl_r) begin
        bx_nx = RX - BALL;
        dx_nx = 1'b0;
      end else if (bx + BALL_STEP > BX_MAX) begin
        miss_r = 1'b1;
      end else begin
        bx_nx = bx + BALL_STEP;
      end
    end
  end

  // On a point dy is left untouched and the serve heads toward the player who lost it.
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= SERVE;
      cnt     <= '0;
      score_l <= '0;
      score_r <= '0;
      py_l    <= PY_C;
      py_r    <= PY_C;
      bx      <= BX_C;
      by      <= BY_C;
      dx      <= 1'b1;
      dy      <= 1'b1;
    end else if (tick) begin
      case (state)
        SERVE: begin
          py_l <= py_l_nx;
          py_r <= py_r_nx;
          if (cnt == SERVE_FRAMES - 10'd1) begin
            cnt   <= '0;
            state <= PLAY;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        PLAY: begin
          py_l <= py_l_nx;
          py_r <= py_r_nx;
          if (miss_l) begin
            score_r <= score_r + 4'd1;
            bx      <= BX_C;
            by      <= BY_C;
            dx      <= 1'b0;
            cnt     <= '0;
            state   <= (score_r + 4'd1 == WIN_SCORE) ? OVER : SERVE;
          end else if (miss_r) begin
            score_l <= score_l + 4'd1;
            bx      <= BX_C;
            by      <= BY_C;
            dx      <= 1'b1;
            cnt     <= '0;
            state   <= (score_l + 4'd1 == WIN_SCORE) ? OVER : SERVE;
          end else begin
            bx <= bx_nx;
            by <= by_nx;
            dx <= dx_nx;
            dy <= dy_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign x       = hc - HBP;
  assign y       = vc - VBP;
  assign in_ball = (x >= bx) && (x < bx + BALL) && (y >= by) && (y < by + BALL);
  assign in_lpad = (x >= LX) && (x < LX + PAD_W) && (y >= py_l) && (y < py_l + PAD_H);
  assign in_rpad = (x >= RX) && (x < RX + PAD_W) && (y >= py_r) && (y < py_r + PAD_H);
  assign in_net  = ((x == NET_L) || (x == NET_R)) && !y[3];

  always_comb begin
    {red, green, blue} = 8'h00;
    if (vidon && !clr) begin
      if (in_ball)
        {red, green, blue} = 8'hFF;
      else if (in_lpad)
        {red, green, blue} = 8'h1C;
      else if (in_rpad)
        {red, green, blue} = 8'hFC;
      else if (in_net)
        {red, green, blue} = 8'h6D;
      else if (state == OVER)
        {red, green, blue} = 8'h80;
    end
  end

endmodule

// File: tb/tb_pong_game.sv
// Self-checking bench for pong_game: directed reset/serve/paddle/game-over steps plus
// randomized buttons and pixel probes checked against a frame-level game model.
module tb_pong_game;

  logic       clk, clr, vidon, up, dn;
  logic [9:0] hc, vc;
  logic [2:0] red, green;
  logic [1:0] blue;
  logic [3:0] score_l, score_r;

  int checks = 0;
  int errors = 0;

  localparam int M_SERVE = 0;
  localparam int M_PLAY  = 1;
  localparam int M_OVER  = 2;

  int mState, mCnt, mBx, mBy, mDx, mDy, mPl, mPr, mSl, mSr;

  pong_game dut (
    .clk(clk), .clr(clr), .vidon(vidon), .hc(hc), .vc(vc), .up(up), .dn(dn),
    .red(red), .green(green), .blue(blue), .score_l(score_l), .score_r(score_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void modelReset();
    mState = M_SERVE; mCnt = 0; mBx = 316; mBy = 236; mDx = 1; mDy = 1;
    mPl = 208; mPr = 208; mSl = 0; mSr = 0;
  endfunction

  function automatic int track(input int py, input int ballY);
    int d;
    d = (ballY + 4) - (py + 32);
    if (d > 2) return (py + 2 > 416) ? 416 : py + 2;
    if (d < -2) return (py < 2) ? 0 : py - 2;
    return py;
  endfunction

  function automatic void scorePoint(input bit rightScored);
    if (rightScored) begin mSr++; mDx = -1; end
    else begin mSl++; mDx = 1; end
    mBx = 316; mBy = 236; mCnt = 0;
    mState = (mSl == 9 || mSr == 9) ? M_OVER : M_SERVE;
  endfunction

  // One frame of the game, written directly from the rules with signed integers.
  function automatic void modelTick(input logic u, input logic d);
    int pl0, pr0, by0, nbx, nby, ndx, ndy;
    if (mState == M_OVER) return;
    pl0 = mPl; pr0 = mPr; by0 = mBy;
`ifdef PONG_ATTRACT_EN
    mPl = track(pl0, by0);
`else
    if (u && !d) mPl = (pl0 - 4 < 0) ? 0 : pl0 - 4;
    else if (d && !u) mPl = (pl0 + 4 > 416) ? 416 : pl0 + 4;
`endif
    mPr = track(pr0, by0);
    if (mState == M_SERVE) begin
      mCnt++;
      if (mCnt == 60) begin mCnt = 0; mState = M_PLAY; end
      return;
    end
    nby = by0 + 2 * mDy; ndy = mDy;
    if (nby < 0) begin nby = 0; ndy = 1; end
    else if (nby > 472) begin nby = 472; ndy = -1; end
    nbx = mBx + 2 * mDx; ndx = mDx;
    if (mDx < 0) begin
      if (nbx < 24 && by0 + 8 > pl0 && by0 < pl0 + 64) begin nbx = 24; ndx = 1; end
      else if (nbx < 0) begin scorePoint(1'b1); return; end
    end else begin
      if (nbx + 8 > 616 && by0 + 8 > pr0 && by0 < pr0 + 64) begin nbx = 608; ndx = -1; end
      else if (nbx > 632) begin scorePoint(1'b0); return; end
    end
    mBx = nbx; mBy = nby; mDx = ndx; mDy = ndy;
  endfunction

  function automatic logic [7:0] expRgb(input int px, input int py, input logic vid, input logic rst);
    if (!vid || rst) return 8'h00;
    if (px >= mBx && px < mBx + 8 && py >= mBy && py < mBy + 8) return 8'hFF;
    if (px >= 16 && px < 24 && py >= mPl && py < mPl + 64) return 8'h1C;
    if (px >= 616 && px < 624 && py >= mPr && py < mPr + 64) return 8'hFC;
    if ((px == 319 || px == 320) && (py % 16) < 8) return 8'h6D;
    return (mState == M_OVER) ? 8'h80 : 8'h00;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic u, input logic d);
    @(negedge clk);
    up = u; dn = d; vidon = 1'b0; hc = 10'd0; vc = 10'd511;
    @(posedge clk);
    #1;
    hc = 10'd1; vc = 10'd0;
    modelTick(u, d);
  endtask

  task automatic probeConst(input int px, input int py, input logic vid, input logic [7:0] exp, input string tag);
    hc = 10'(px + 144); vc = 10'(py + 31); vidon = vid;
    #1;
    checkOutput(tag, 32'({red, green, blue}), 32'(exp));
  endtask

  task automatic probePixel(input int px, input int py, input logic vid, input string tag);
    hc = 10'(px + 144); vc = 10'(py + 31); vidon = vid;
    #1;
    checkOutput(tag, 32'({red, green, blue}), 32'(expRgb(px, py, vid, clr)));
  endtask

  task automatic tickChecks(input string tag);
    checkOutput({tag, "_score_l"}, 32'(score_l), 32'(mSl));
    checkOutput({tag, "_score_r"}, 32'(score_r), 32'(mSr));
    probePixel(mBx, mBy, 1'b1, {tag, "_ball_tl"});
    probePixel(mBx + 7, mBy + 7, 1'b1, {tag, "_ball_br"});
    probePixel(20, mPl, 1'b1, {tag, "_lpad_top"});
    probePixel(620, mPr + 63, 1'b1, {tag, "_rpad_bot"});
    probePixel(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'b1, {tag, "_rand_px"});
    probePixel(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
               1'($urandom_range(0, 3) != 0), {tag, "_rand_px2"});
  endtask

  initial begin
    int n;
    clr = 1'b1; vidon = 1'b0; hc = 10'd1; vc = 10'd0; up = 1'b0; dn = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    probeConst(316, 236, 1'b1, 8'h00, "rgb_during_clr");
    @(negedge clk);
    clr = 1'b0;
    probeConst(316, 236, 1'b1, 8'hFF, "reset_ball_pixel");
    probeConst(316, 236, 1'b0, 8'h00, "reset_vidon_off");
    checkOutput("reset_score_l", 32'(score_l), 32'd0);
    checkOutput("reset_score_r", 32'(score_r), 32'd0);

`ifndef PONG_ATTRACT_EN
    for (int i = 1; i <= 51; i++) begin
      applyStimulus(1'b1, 1'b0);
      tickChecks("serve_up");
      probeConst(316, 236, 1'b1, 8'hFF, "serve_ball_held");
    end
    probeConst(16, 3, 1'b1, 8'h00, "lpad_tick51_above");
    probeConst(16, 4, 1'b1, 8'h1C, "lpad_tick51_top");
    applyStimulus(1'b1, 1'b0);
    probeConst(16, 0, 1'b1, 8'h1C, "lpad_at_zero");
    probeConst(16, 64, 1'b1, 8'h00, "lpad_at_zero_below");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0);
      probeConst(16, 0, 1'b1, 8'h1C, "lpad_clamped_top");
      probeConst(16, 63, 1'b1, 8'h1C, "lpad_clamped_bot");
      probeConst(16, 64, 1'b1, 8'h00, "lpad_clamped_below");
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1);
      probeConst(16, 0, 1'b1, 8'h1C, "lpad_both_hold");
      probeConst(16, 64, 1'b1, 8'h00, "lpad_both_hold_below");
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0);
      tickChecks("serve_tail");
    end
`else
    for (int i = 1; i <= 60; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tickChecks("serve_attract");
      probeConst(316, 236, 1'b1, 8'hFF, "serve_ball_held");
    end
`endif
    probeConst(316, 236, 1'b1, 8'hFF, "serve_tick60_ball");
    applyStimulus(1'b1, 1'b0);
    probeConst(318, 238, 1'b1, 8'hFF, "first_move_ball");
    probeConst(317, 237, 1'b1, 8'h00, "first_move_vacated");
    tickChecks("first_move");

    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tickChecks("random_play");
    end

`ifndef PONG_ATTRACT_EN
    n = 0;
    while (mState != M_OVER && n < 20000) begin
      applyStimulus(1'b1, 1'b0);
      tickChecks("pinned_play");
      n++;
    end
    checkOutput("over_within_budget", 32'(n < 20000), 32'd1);
    probeConst(100, 5, 1'b1, 8'h80, "over_background");
    probeConst(316, 236, 1'b1, 8'hFF, "over_ball_centre");
    checkOutput("over_score_r", 32'(score_r), 32'd9);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1);
      tickChecks("over_frozen");
      probeConst(316, 236, 1'b1, 8'hFF, "over_ball_frozen");
      probeConst(16, 0, 1'b1, 8'h1C, "over_lpad_frozen");
    end
`else
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b0);
      tickChecks("attract_play");
    end
`endif

    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    probeConst(316, 236, 1'b1, 8'h00, "rgb_during_clr2");
    @(negedge clk);
    clr = 1'b0;
    modelReset();
    checkOutput("clr_score_l", 32'(score_l), 32'd0);
    checkOutput("clr_score_r", 32'(score_r), 32'd0);
    probeConst(100, 5, 1'b1, 8'h00, "clr_background");
    probeConst(316, 236, 1'b1, 8'hFF, "clr_ball_centre");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0);
      tickChecks("post_clr_serve");
      probeConst(316, 236, 1'b1, 8'hFF, "post_clr_ball_held");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
